// File: rtl/lock_ctrl.sv
// Keypad lock sequencer: collects four-digit codes, unlocks on a secret match,
// counts failures into a timed alarm lockout, and reprograms the secret while open.
module lock_ctrl #(
  parameter logic [15:0] SECRET      = 16'h7310,
  parameter int          MAX_FAIL    = 3,
  parameter int          TIMEOUT_CYC = 32,
  parameter int          LOCKOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] tenkey,
  input  logic       close,
  input  logic       set_mode,
  output logic       lock,
  output logic       alarm,
  output logic       entering,
  output logic [2:0] digit_cnt,
  output logic [1:0] fail_cnt
);

  typedef enum logic [2:0] {IDLE, ENTRY, UNLOCKED, PROGRAM, LOCKOUT} state_t;

  state_t      state;
  logic [9:0]  prev;
  // Only the three older digits need storing; the fourth arrives with the deciding press.
  logic [11:0] entry;
  logic [15:0] secret;
  logic [7:0]  timer;

  logic        press;
  logic [3:0]  digit;
  logic [15:0] entry_shift;
  logic        timeout;
  logic        lock_expired;
  logic [1:0]  fail_inc;

  always_comb begin
    digit = '0;
    for (int k = 0; k < 10; k++) begin
      if (tenkey[k]) digit = 4'(k);
    end
    press        = $onehot(tenkey) && (prev == '0);
    entry_shift  = {entry, digit};
    timeout      = (timer == 8'(TIMEOUT_CYC - 1));
    lock_expired = (timer == 8'(LOCKOUT_CYC - 1));
    fail_inc     = (fail_cnt == 2'(MAX_FAIL)) ? fail_cnt : fail_cnt + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prev      <= '0;
      entry     <= '0;
      secret    <= SECRET;
      timer     <= '0;
      lock      <= 1'b1;
      alarm     <= 1'b0;
      entering  <= 1'b0;
      digit_cnt <= '0;
      fail_cnt  <= '0;
    end else begin
      prev <= tenkey;
      case (state)
        IDLE: begin
          if (press) begin
            state     <= ENTRY;
            entering  <= 1'b1;
            digit_cnt <= 3'd1;
            entry     <= {8'h00, digit};
            timer     <= '0;
          end
        end
        ENTRY: begin
          if (close || timeout) begin
            state     <= IDLE;
            entering  <= 1'b0;
            digit_cnt <= '0;
            timer     <= '0;
          end else if (press) begin
            timer <= '0;
            if (digit_cnt == 3'd3) begin
              entering  <= 1'b0;
              digit_cnt <= '0;
              if (entry_shift == secret) begin
                state    <= UNLOCKED;
                lock     <= 1'b0;
                fail_cnt <= '0;
              end else begin
                fail_cnt <= fail_inc;
                if (fail_inc == 2'(MAX_FAIL)) begin
                  state <= LOCKOUT;
                  alarm <= 1'b1;
                end else begin
                  state <= IDLE;
                end
              end
            end else begin
              digit_cnt <= digit_cnt + 3'd1;
              entry     <= entry_shift[11:0];
            end
          end else begin
            timer <= timer + 8'd1;
          end
        end
        UNLOCKED: begin
          if (close) begin
            state <= IDLE;
            lock  <= 1'b1;
          end else if (set_mode) begin
            state     <= PROGRAM;
            entering  <= 1'b1;
            digit_cnt <= '0;
            timer     <= '0;
          end
        end
        PROGRAM: begin
          if (close) begin
            state     <= IDLE;
            lock      <= 1'b1;
            entering  <= 1'b0;
            digit_cnt <= '0;
            timer     <= '0;
          end else if (timeout) begin
            state     <= UNLOCKED;
            entering  <= 1'b0;
            digit_cnt <= '0;
            timer     <= '0;
          end else if (press) begin
            timer <= '0;
            if (digit_cnt == 3'd3) begin
              secret    <= entry_shift;
              state     <= UNLOCKED;
              entering  <= 1'b0;
              digit_cnt <= '0;
            end else begin
              digit_cnt <= digit_cnt + 3'd1;
              entry     <= entry_shift[11:0];
            end
          end else begin
            timer <= timer + 8'd1;
          end
        end
        LOCKOUT: begin
          // Inputs are deliberately ignored here, including a press on the exit edge.
          if (lock_expired) begin
            state    <= IDLE;
            alarm    <= 1'b0;
            fail_cnt <= '0;
            timer    <= '0;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lock_ctrl.sv
// Directed bench for lock_ctrl: expected output vectors are queued as stimulus is
// driven and compared after each clock edge.
module tb_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] tenkey;
  logic       close;
  logic       set_mode;
  logic       lock;
  logic       alarm;
  logic       entering;
  logic [2:0] digit_cnt;
  logic [1:0] fail_cnt;

  typedef struct {
    string      tag;
    logic [7:0] v;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  lock_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tenkey   (tenkey),
    .close    (close),
    .set_mode (set_mode),
    .lock     (lock),
    .alarm    (alarm),
    .entering (entering),
    .digit_cnt(digit_cnt),
    .fail_cnt (fail_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] st(input logic l, input logic a, input logic e,
                                    input logic [2:0] d, input logic [1:0] f);
    return {l, a, e, d, f};
  endfunction

  task automatic push(input string tag, input logic [7:0] v);
    exp_t x;
    x.tag = tag;
    x.v   = v;
    sb.push_back(x);
  endtask

  task automatic check();
    exp_t       x;
    logic [7:0] obs;
    x   = sb.pop_front();
    obs = {lock, alarm, entering, digit_cnt, fail_cnt};
    compared++;
    assert (obs === x.v) else begin
      mismatched++;
      $error("FAIL %s observed(lock,alarm,entering,dcnt,fail)=%b expected=%b", x.tag, obs, x.v);
    end
    $display("step %-18s lock=%b alarm=%b entering=%b digit_cnt=%0d fail_cnt=%0d", x.tag,
             lock, alarm, entering, digit_cnt, fail_cnt);
  endtask

  task automatic step_chk(input logic [9:0] k, input logic c, input logic s,
                          input string tag, input logic [7:0] e);
    @(negedge clk);
    tenkey   = k;
    close    = c;
    set_mode = s;
    push(tag, e);
    @(posedge clk);
    #1;
    check();
  endtask

  task automatic cyc(input logic [9:0] k);
    @(negedge clk);
    tenkey   = k;
    close    = 1'b0;
    set_mode = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Key held 3 cycles then released 2; the result is checked at the accepting edge.
  task automatic press(input int d, input string tag, input logic [7:0] e);
    logic [9:0] k;
    k = 10'd1 << d;
    step_chk(k, 1'b0, 1'b0, tag, e);
    cyc(k);
    cyc(k);
    cyc(10'd0);
    cyc(10'd0);
  endtask

  task automatic enter_code(input logic [15:0] code, input logic in_prog, input logic [1:0] f,
                            input string tag, input logic [7:0] final_e);
    for (int i = 0; i < 3; i++) begin
      press(int'(code[15-4*i -: 4]), $sformatf("%s_d%0d", tag, i + 1),
            st(!in_prog, 1'b0, 1'b1, in_prog ? 3'(i + 1) : 3'(i + 1), f));
    end
    press(int'(code[3:0]), $sformatf("%s_d4", tag), final_e);
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clk);
    tenkey   = '0;
    close    = 1'b0;
    set_mode = 1'b0;
    rst_n    = 1'b0;
    push(tag, st(1'b1, 1'b0, 1'b0, 3'd0, 2'd0));
    #1;
    check();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [9:0] kk;
    rst_n    = 1'b0;
    tenkey   = '0;
    close    = 1'b0;
    set_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push("reset", st(1'b1, 1'b0, 1'b0, 3'd0, 2'd0));
    check();
    @(negedge clk);
    rst_n = 1'b1;

    // Correct code unlocks at the edge accepting the last digit; close relocks.
    enter_code(16'h7310, 1'b0, 2'd0, "unlock1", st(1'b0, 1'b0, 1'b0, 3'd0, 2'd0));
    step_chk(10'd0, 1'b1, 1'b0, "close1", st(1'b1, 1'b0, 1'b0, 3'd0, 2'd0));

    // Three wrong codes lead to a 16-cycle lockout that ignores all inputs.
    enter_code(16'h1234, 1'b0, 2'd0, "wrong1", st(1'b1, 1'b0, 1'b0, 3'd0, 2'd1));
    enter_code(16'h1234, 1'b0, 2'd1, "wrong2", st(1'b1, 1'b0, 1'b0, 3'd0, 2'd2));
    press(1, "wrong3_d1", st(1'b1, 1'b0, 1'b1, 3'd1, 2'd2));
    press(2, "wrong3_d2", st(1'b1, 1'b0, 1'b1, 3'd2, 2'd2));
    press(3, "wrong3_d3", st(1'b1, 1'b0, 1'b1, 3'd3, 2'd2));
    step_chk(10'd1 << 4, 1'b0, 1'b0, "lockout_enter", st(1'b1, 1'b1, 1'b0, 3'd0, 2'd3));
    for (int i = 1; i <= 15; i++) begin
      kk = (i % 3 == 1) ? (10'd1 << 5) : 10'd0;
      step_chk(kk, i == 8, i == 9, $sformatf("lockout_%0d", i), st(1'b1, 1'b1, 1'b0, 3'd0, 2'd3));
    end
    step_chk(10'd1 << 2, 1'b0, 1'b0, "lockout_exit", st(1'b1, 1'b0, 1'b0, 3'd0, 2'd0));
    step_chk(10'd0, 1'b0, 1'b0, "after_exit", st(1'b1, 1'b0, 1'b0, 3'd0, 2'd0));
    enter_code(16'h7310, 1'b0, 2'd0, "unlock2", st(1'b0, 1'b0, 1'b0, 3'd0, 2'd0));
    step_chk(10'd0, 1'b1, 1'b0, "close2", st(1'b1, 1'b0, 1'b0, 3'd0, 2'd0));

    // Partial entry times out after 32 press-free edges without counting a failure.
    enter_code(16'h1234, 1'b0, 2'd0, "wrong4", st(1'b1, 1'b0, 1'b0, 3'd0, 2'd1));
    press(7, "to_d1", st(1'b1, 1'b0, 1'b1, 3'd1, 2'd1));
    step_chk(10'd1 << 3, 1'b0, 1'b0, "to_d2", st(1'b1, 1'b0, 1'b1, 3'd2, 2'd1));
    for (int i = 1; i <= 31; i++) begin
      kk = (i <= 2) ? (10'd1 << 3) : 10'd0;
      step_chk(kk, 1'b0, 1'b0, $sformatf("to_wait_%0d", i), st(1'b1, 1'b0, 1'b1, 3'd2, 2'd1));
    end
    step_chk(10'd0, 1'b0, 1'b0, "to_fire", st(1'b1, 1'b0, 1'b0, 3'd0, 2'd1));
    enter_code(16'h7310, 1'b0, 2'd1, "unlock3", st(1'b0, 1'b0, 1'b0, 3'd0, 2'd0));

    // Reprogram to 5592: old code then fails, new code unlocks.
    step_chk(10'd0, 1'b0, 1'b1, "set_mode", st(1'b0, 1'b0, 1'b1, 3'd0, 2'd0));
    enter_code(16'h5592, 1'b1, 2'd0, "prog1", st(1'b0, 1'b0, 1'b0, 3'd0, 2'd0));
    step_chk(10'd0, 1'b1, 1'b0, "close3", st(1'b1, 1'b0, 1'b0, 3'd0, 2'd0));
    enter_code(16'h7310, 1'b0, 2'd0, "old_code", st(1'b1, 1'b0, 1'b0, 3'd0, 2'd1));
    enter_code(16'h5592, 1'b0, 2'd1, "new_code", st(1'b0, 1'b0, 1'b0, 3'd0, 2'd0));
    step_chk(10'd0, 1'b1, 1'b0, "close4", st(1'b1, 1'b0, 1'b0, 3'd0, 2'd0));

    // Held key counts once; multi-hot values are rejected and block a following one-hot.
    for (int i = 0; i < 20; i++) begin
      step_chk(10'b0010000000, 1'b0, 1'b0, $sformatf("hold_%0d", i), st(1'b1, 1'b0, 1'b1, 3'd1, 2'd0));
    end
    step_chk(10'd0, 1'b0, 1'b0, "hold_release", st(1'b1, 1'b0, 1'b1, 3'd1, 2'd0));
    step_chk(10'b0000001010, 1'b0, 1'b0, "multi_hot", st(1'b1, 1'b0, 1'b1, 3'd1, 2'd0));
    step_chk(10'b0000001000, 1'b0, 1'b0, "no_release", st(1'b1, 1'b0, 1'b1, 3'd1, 2'd0));
    step_chk(10'd0, 1'b0, 1'b0, "release2", st(1'b1, 1'b0, 1'b1, 3'd1, 2'd0));
    press(3, "close_d2", st(1'b1, 1'b0, 1'b1, 3'd2, 2'd0));
    press(1, "close_d3", st(1'b1, 1'b0, 1'b1, 3'd3, 2'd0));
    step_chk(10'd1 << 0, 1'b1, 1'b0, "close_vs_d4", st(1'b1, 1'b0, 1'b0, 3'd0, 2'd0));
    step_chk(10'd0, 1'b0, 1'b0, "close_after", st(1'b1, 1'b0, 1'b0, 3'd0, 2'd0));

    // Reset mid-entry, and after reprogramming with a pending failure.
    press(7, "rst_d1", st(1'b1, 1'b0, 1'b1, 3'd1, 2'd0));
    press(3, "rst_d2", st(1'b1, 1'b0, 1'b1, 3'd2, 2'd0));
    press(1, "rst_d3", st(1'b1, 1'b0, 1'b1, 3'd3, 2'd0));
    reset_pulse("reset_mid_entry");
    enter_code(16'h7310, 1'b0, 2'd0, "unlock4", st(1'b0, 1'b0, 1'b0, 3'd0, 2'd0));
    step_chk(10'd0, 1'b0, 1'b1, "set_mode2", st(1'b0, 1'b0, 1'b1, 3'd0, 2'd0));
    enter_code(16'h5592, 1'b1, 2'd0, "prog2", st(1'b0, 1'b0, 1'b0, 3'd0, 2'd0));
    step_chk(10'd0, 1'b1, 1'b0, "close5", st(1'b1, 1'b0, 1'b0, 3'd0, 2'd0));
    enter_code(16'h1111, 1'b0, 2'd0, "wrong5", st(1'b1, 1'b0, 1'b0, 3'd0, 2'd1));
    reset_pulse("reset_after_prog");
    enter_code(16'h5592, 1'b0, 2'd0, "lost_code", st(1'b1, 1'b0, 1'b0, 3'd0, 2'd1));
    enter_code(16'h7310, 1'b0, 2'd1, "unlock5", st(1'b0, 1'b0, 1'b0, 3'd0, 2'd0));
    step_chk(10'd0, 1'b1, 1'b0, "close6", st(1'b1, 1'b0, 1'b0, 3'd0, 2'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lock_ctrl.md
# lock_ctrl

Sequencing controller for the keypad electronic lock. It turns raw one-hot tenkey presses into a four-digit code entry, compares it against a programmable secret and drives the lock output. It also counts failed attempts, enforces a timed lockout with an alarm, and lets the secret be reprogrammed while unlocked. It sits between the keypad/door-close switch and the lock actuator, replacing the free-running two-digit shift-and-compare lock.

## Interface

- SECRET, 16'h7310, reset value of the secret; four BCD digits, first-entered digit in [15:12].
- MAX_FAIL, 3, consecutive wrong codes that trigger lockout (1..3).
- TIMEOUT_CYC, 32, idle cycles after the last press before a partial entry is discarded (1..255).
- LOCKOUT_CYC, 16, lockout/alarm duration in cycles (1..255).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- tenkey  input  10  keypad level, one-hot, bit k = digit k; 0 = no key.
- close  input  1  door-close request, level.
- set_mode  input  1  request to reprogram the secret, level.
- lock  output  1  1 = locked; reset 1.
- alarm  output  1  1 during lockout; reset 0.
- entering  output  1  1 in ENTRY or PROGRAM; reset 0.
- digit_cnt  output  3  digits collected in current entry (0..3); reset 0.
- fail_cnt  output  2  consecutive wrong codes; reset 0.

## Operation

- Press detection: tenkey is registered every edge (prev, reset 0). A press is accepted at an edge where tenkey is exactly one-hot and prev == 0. Held keys count once. Multi-hot or zero values are never accepted. A multi-hot value still updates prev, so release to 0 is required before the next press is accepted.
- Digits shift into a 16-bit entry register, newest digit in [3:0].
- States: IDLE (reset), ENTRY, UNLOCKED, PROGRAM, LOCKOUT.
- IDLE (lock=1):
  - accepted press -> ENTRY, digit_cnt=1.
  - close has no effect.
- ENTRY (lock=1):
  - Each press increments digit_cnt.
  - On the 4th press, the shifted value including that digit is compared to the secret at the same edge.
  - Match -> UNLOCKED, lock=0, fail_cnt=0.
  - Mismatch -> fail_cnt+1. If the new fail_cnt == MAX_FAIL -> LOCKOUT, alarm=1, otherwise -> IDLE.
  - close -> IDLE, entry discarded, fail_cnt unchanged.
  - Timeout -> IDLE, not counted as a failure.
- UNLOCKED (lock=0):
  - close -> IDLE, lock=1.
  - Otherwise set_mode -> PROGRAM, digit_cnt=0.
  - Presses are ignored.
- PROGRAM (lock=0):
  - Collects 4 presses. At the edge of the 4th press, secret := entry value -> UNLOCKED.
  - Timeout -> UNLOCKED, secret unchanged.
  - close -> IDLE, lock=1, secret unchanged.
- LOCKOUT (lock=1, alarm=1):
  - Presses, close and set_mode are ignored.
  - At expiry -> IDLE, alarm=0, fail_cnt=0.
- Priority at one edge: reset > close > timeout > press > set_mode.
- digit_cnt returns to 0 on every exit from ENTRY/PROGRAM.
- Reset mid-operation: all state, the entry register, timers and prev are cleared, and secret returns to SECRET. Programmed secrets do not survive reset.

## Timing

- All outputs are registered and change only at clk edges or on async reset assertion.
- Unlock latency: lock falls at the same edge that accepts the 4th correct digit. This is 1 cycle after tenkey first shows that digit.
- Entry timer (8 bit):
  - Cleared at every accepted press and on entering ENTRY/PROGRAM.
  - Increments each edge in ENTRY/PROGRAM.
  - The timeout transition fires at the TIMEOUT_CYC-th consecutive edge with no accepted press.
- Lockout timer: if entered at edge E, alarm is high for exactly LOCKOUT_CYC cycles. State is IDLE and alarm=0 after edge E+LOCKOUT_CYC.
- A press accepted at the edge that leaves LOCKOUT is ignored.
- fail_cnt saturates at MAX_FAIL and never wraps.

## Test plan

- Reset, then press 7,3,1,0, each held 3 cycles with 2 idle cycles between -> lock=0 at the edge accepting "0", fail_cnt=0. Then assert close for 1 cycle -> lock=1, state IDLE.
- Enter 1,2,3,4 three times (MAX_FAIL=3) -> fail_cnt 1, 2, then alarm=1 for exactly 16 cycles. Keys pressed during lockout are ignored. Afterwards fail_cnt=0 and 7,3,1,0 unlocks.
- Press 7,3 then idle 32 cycles -> entering=0 and digit_cnt=0 at the 32nd edge, fail_cnt unchanged. Then 7,3,1,0 unlocks.
- Unlock, assert set_mode, press 5,5,9,2 -> back to UNLOCKED. close, then 7,3,1,0 -> fail_cnt=1, lock=1. Then 5,5,9,2 -> lock=0.
- Hold tenkey=10'b0010000000 for 20 cycles -> digit_cnt=1 only. Drive 10'b0000001010 -> no press accepted. Assert close in the same cycle as the 4th correct digit -> lock stays 1, state IDLE.
- Assert rst_n=0 for 1 cycle after 3 digits of entry, and again after reprogramming -> lock=1, alarm=0, digit_cnt=0, fail_cnt=0. The secret reverts to 16'h7310.
